cdb_arbiter_param: RTL
======================

Name: cdb_arbiter_param

Overview:
Parametrised common-data-bus arbiter and result mux, the successor to the fixed int/ls/mult/div issue logic.
- Arbitrates NUM_SC single-cycle requesters (integer, load/store, ...) round-robin.
- Serves NUM_FL fixed-latency pipelined units through a CDB slot-reservation shift register.
- Adds a flush that cancels reserved slots.
- Sits between the functional-unit queues and the CDB consumers (RS, ROB, register status).

Parameters:
NUM_SC, 2, number of single-cycle requesters (>=1)
NUM_FL, 2, number of fixed-latency units (>=1)
FL_LAT, {3,6}, per-FL-unit latency array, each 1..15; MAX_LAT = max(FL_LAT)
TAG_W, 6, tag width
DATA_W, 32, result width
SB_W, 5, sideband width (branch, branch_taken, jalr, store_pc, valid) for SC channels only

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sc_req  in  NUM_SC  single-cycle result ready
sc_tag  in  NUM_SC*TAG_W  per-channel tag
sc_data  in  NUM_SC*DATA_W  per-channel result
sc_sb  in  NUM_SC*SB_W  per-channel sideband
sc_grant  out  NUM_SC  one-hot "done"; result drives CDB this cycle
fl_req  in  NUM_FL  unit wants to issue; held until granted
fl_tag  in  NUM_FL*TAG_W  tag at unit output stage
fl_data  in  NUM_FL*DATA_W  result at unit output stage
fl_grant  out  NUM_FL  issue accepted this cycle
flush  in  1  cancel all reservations
cdb_valid  out  1  CDB carries a result
cdb_tag  out  TAG_W  CDB tag
cdb_data  out  DATA_W  CDB data
cdb_sb  out  SB_W  CDB sideband (0 for FL sources)
cdb_src  out  clog2(NUM_SC+NUM_FL)  source: SC index 0..NUM_SC-1, FL k = NUM_SC+k

Behaviour:
- The only state is:
  - res[0..MAX_LAT]: reservation bit plus owner index. res[i] means the CDB in cycle t+i is taken.
  - rr_ptr: clog2(NUM_SC) bits.
- Reset: at a clk edge with rst=1, all res entries and rr_ptr clear to 0. While rst=1, all grants are 0, cdb_valid=0, and cdb_tag/data/sb/src are 0.
- FL grant, combinational:
  - Unit k is granted iff fl_req[k]=1, res[FL_LAT[k]] is free, and no lower-index unit with equal latency is granted this cycle.
  - Unequal-latency grants in the same cycle are independent.
- Shift: at each edge, res[i] <= res[i+1]; res[MAX_LAT] <= free. A grant for unit k additionally sets res[FL_LAT[k]-1] with owner k. Result: a grant in cycle t owns the CDB in cycle t+FL_LAT[k].
- SC grant, combinational:
  - Only when res[0] is free.
  - Scan from rr_ptr upward with wrap; the first requester is granted.
  - At the edge, rr_ptr <= granted index + 1 (mod NUM_SC). rr_ptr is unchanged when there is no SC grant.
  - When res[0] is taken, every sc_grant is 0 and rr_ptr holds.
- CDB mux, combinational:
  - If res[0] is taken by owner k: drive fl_tag[k]/fl_data[k], sb=0, src=NUM_SC+k, cdb_valid=1.
  - Else if an SC channel j is granted: drive its tag, data and sb, src=j, cdb_valid=1.
  - Else: all outputs 0.
- Flush:
  - In the flush cycle all grants are 0 and cdb_valid=0.
  - At the edge every res entry is cleared; rr_ptr holds.
  - FL units discard their own in-flight operations.
- At most one grant targets any slot; the CDB is never double-driven. The bench asserts sc_grant is one-hot-or-zero and that cdb_valid is never set with both an FL owner and an SC grant.
- Starvation bound: an SC requester held high waits at most NUM_SC-1 SC-grant cycles, plus cycles whose slot is reserved.

Test Plan:
- No FL traffic, sc_req=2'b11 held for 4 cycles after reset -> sc_grant sequence 01,10,01,10; cdb_src 0,1,0,1; cdb_valid=1 each cycle.
- fl_req[0] pulsed at cycle 10 (FL_LAT[0]=3), sc_req[0] held high -> fl_grant[0]=1 at 10. Cycle 13: cdb_src=2, cdb_tag=fl_tag[0], sc_grant=0. Cycles 12 and 14: sc_grant[0]=1.
- fl_req[1] at cycle 7 (lat 6); fl_req[0] high from cycle 10 (lat 3) -> FL1 granted at 7 and owns 13. FL0 denied at 10, granted at 11, owns 14.
- FL_LAT={3,3}, both fl_req high at cycle 5 -> fl_grant=01 at 5, fl_grant=10 at 6; CDB src 2 at 8, src 3 at 9.
- FL0 granted at cycle 10, flush=1 at cycle 12 -> cycle 12: cdb_valid=0, grants 0. Cycle 13: no FL owner; a pending sc_req is granted.
- FL1 granted at cycle 20, rst=1 at cycle 22 for 1 cycle -> outputs 0 during 22. At cycle 26 cdb_valid=0 with no FL owner; rr_ptr=0 from cycle 23.

Source files
------------

// File: rtl/cdb_arbiter_param.sv
// Parametrised CDB arbiter: round-robin single-cycle requesters, slot-reserved
// fixed-latency units, and the result mux that drives the common data bus.
module cdb_arbiter_param #(
   parameter int                  NUM_SC = 2,
   parameter int                  NUM_FL = 2,
   // 4 bits per FL unit, unit k at [k*4 +: 4], each 1..15
   parameter logic [NUM_FL*4-1:0] FL_LAT = {4'd6, 4'd3},
   parameter int                  TAG_W  = 6,
   parameter int                  DATA_W = 32,
   parameter int                  SB_W   = 5,
   localparam int                 SRC_W  = $clog2(NUM_SC + NUM_FL)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SC-1:0]          sc_req,
   input  logic [NUM_SC*TAG_W-1:0]    sc_tag,
   input  logic [NUM_SC*DATA_W-1:0]   sc_data,
   input  logic [NUM_SC*SB_W-1:0]     sc_sb,
   output logic [NUM_SC-1:0]          sc_grant,
   input  logic [NUM_FL-1:0]          fl_req,
   input  logic [NUM_FL*TAG_W-1:0]    fl_tag,
   input  logic [NUM_FL*DATA_W-1:0]   fl_data,
   output logic [NUM_FL-1:0]          fl_grant,
   input  logic                       flush,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_data,
   output logic [SB_W-1:0]            cdb_sb,
   output logic [SRC_W-1:0]           cdb_src
);

   function automatic int lat_of(input int k);
      return int'(FL_LAT[k*4 +: 4]);
   endfunction

   function automatic int calc_max_lat();
      int m;
      m = 1;
      for (int k = 0; k < NUM_FL; k++)
         if (lat_of(k) > m) m = lat_of(k);
      return m;
   endfunction

   localparam int MAX_LAT = calc_max_lat();
   localparam int OWN_W   = (NUM_FL > 1) ? $clog2(NUM_FL) : 1;
   localparam int PTR_W   = (NUM_SC > 1) ? $clog2(NUM_SC) : 1;

   // res_vld[i]/res_own[i]: the CDB slot i cycles from now and the FL unit owning it
   logic [MAX_LAT:0] res_vld;
   logic [OWN_W-1:0] res_own [MAX_LAT+1];
   logic [PTR_W-1:0] rr_ptr;

   logic [NUM_FL-1:0] fl_slot_busy;
   logic              sc_hit;
   logic [PTR_W-1:0]  sc_idx;
   logic [PTR_W-1:0]  rr_nxt;
   logic              bus_open;

   assign bus_open = !rst && !flush;

   // NOTE: every always_comb variable gets a default first so no latch is inferred.
   always_comb begin
      fl_slot_busy = '0;
      for (int k = 0; k < NUM_FL; k++)
         for (int i = 1; i <= MAX_LAT; i++)
            if (i == lat_of(k)) fl_slot_busy[k] = res_vld[i];
   end

   // Equal-latency units compete for the same slot; lower index wins.
   always_comb begin
      fl_grant = '0;
      if (bus_open) begin
         for (int k = 0; k < NUM_FL; k++) begin
            fl_grant[k] = fl_req[k] && !fl_slot_busy[k];
            for (int j = 0; j < k; j++)
               if (lat_of(j) == lat_of(k) && fl_grant[j]) fl_grant[k] = 1'b0;
         end
      end
   end

   // Scan from rr_ptr upward with wrap; first requester found wins.
   always_comb begin
      sc_hit = 1'b0;
      sc_idx = '0;
      if (bus_open && !res_vld[0]) begin
         for (int n = 0; n < NUM_SC; n++)
            for (int j = 0; j < NUM_SC; j++)
               if (!sc_hit && sc_req[j] && j == (int'(rr_ptr) + n) % NUM_SC) begin
                  sc_hit = 1'b1;
                  sc_idx = PTR_W'(j);
               end
      end
   end

   always_comb begin
      sc_grant = '0;
      for (int j = 0; j < NUM_SC; j++)
         sc_grant[j] = sc_hit && (int'(sc_idx) == j);
   end

   assign rr_nxt = (int'(sc_idx) + 1 == NUM_SC) ? '0 : PTR_W'(int'(sc_idx) + 1);

   always_comb begin
      cdb_valid = 1'b0;
      cdb_tag   = '0;
      cdb_data  = '0;
      cdb_sb    = '0;
      cdb_src   = '0;
      if (bus_open) begin
         if (res_vld[0]) begin
            cdb_valid = 1'b1;
            for (int k = 0; k < NUM_FL; k++)
               if (int'(res_own[0]) == k) begin
                  cdb_tag  = fl_tag[k*TAG_W +: TAG_W];
                  cdb_data = fl_data[k*DATA_W +: DATA_W];
                  cdb_src  = SRC_W'(NUM_SC + k);
               end
         end else if (sc_hit) begin
            cdb_valid = 1'b1;
            for (int j = 0; j < NUM_SC; j++)
               if (int'(sc_idx) == j) begin
                  cdb_tag  = sc_tag[j*TAG_W +: TAG_W];
                  cdb_data = sc_data[j*DATA_W +: DATA_W];
                  cdb_sb   = sc_sb[j*SB_W +: SB_W];
                  cdb_src  = SRC_W'(j);
               end
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         res_vld <= '0;
         // NOTE: the owner array is cleared too, so a stale owner can never reach the mux.
         for (int i = 0; i <= MAX_LAT; i++) res_own[i] <= '0;
         if (rst) rr_ptr <= '0;
      end else begin
         res_vld <= {1'b0, res_vld[MAX_LAT:1]};
         for (int i = 0; i < MAX_LAT; i++) res_own[i] <= res_own[i+1];
         res_own[MAX_LAT] <= '0;
         // A grant now lands one slot below its latency because the shift happens at the same edge.
         for (int k = 0; k < NUM_FL; k++)
            for (int i = 0; i < MAX_LAT; i++)
               if (fl_grant[k] && i == lat_of(k) - 1) begin
                  res_vld[i] <= 1'b1;
                  res_own[i] <= OWN_W'(k);
               end
         if (sc_hit) rr_ptr <= rr_nxt;
      end
   end

endmodule
